// File: rtl/cordic_job_scheduler_if.sv
// Requester-side and CORDIC-core-side signals of the job scheduler.
// The master modport is the scheduler; the slave modport is the requesters plus the core.
interface cordic_job_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_angle;
  logic [NUM_REQ-1:0]        grant;
  logic                      cordic_start;
  logic [DATA_W-1:0]         cordic_angle;
  logic                      cordic_done;
  logic [DATA_W-1:0]         cordic_x;
  logic [DATA_W-1:0]         cordic_y;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_x;
  logic [DATA_W-1:0]         rsp_y;
  logic                      rsp_err;

  modport master (
    input  req, req_angle, cordic_done, cordic_x, cordic_y,
    output grant, cordic_start, cordic_angle, rsp_valid, rsp_x, rsp_y, rsp_err
  );

  modport slave (
    output req, req_angle, cordic_done, cordic_x, cordic_y,
    input  grant, cordic_start, cordic_angle, rsp_valid, rsp_x, rsp_y, rsp_err
  );
endinterface

// File: rtl/cordic_job_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC core among NUM_REQ requesters.
// Jobs issue only on time-base ticks; a stuck core is aborted after TIMEOUT cycles.
module cordic_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  cordic_job_scheduler_if.master bus,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n, owner, owner_n, winner, cand;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
  logic [NUM_REQ-1:0] grant_q, grant_n, rsp_valid_q, rsp_valid_n;
  logic               start_q, start_n, rsp_err_q, rsp_err_n, found;
  logic [DATA_W-1:0]  angle_q, angle_n, rsp_x_q, rsp_x_n, rsp_y_q, rsp_y_n;
  logic [7:0]         ovr_q, ovr_n;
  logic [DATA_W-1:0]  angle_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) angle_arr[i] = bus.req_angle[i*DATA_W +: DATA_W];
  end

  // Search starts just after the last winner so every requester gets a fair turn.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    owner_n     = owner;
    wait_cnt_n  = wait_cnt;
    grant_n     = '0;
    start_n     = 1'b0;
    angle_n     = angle_q;
    rsp_valid_n = '0;
    rsp_x_n     = rsp_x_q;
    rsp_y_n     = rsp_y_q;
    rsp_err_n   = rsp_err_q;
    ovr_n       = ovr_q;
    unique case (state)
      IDLE: begin
        if (tick && (|bus.req)) begin
          state_n  = ISSUE;
          rr_ptr_n = winner;
          owner_n  = winner;
          angle_n  = angle_arr[winner];
          grant_n  = ONE_HOT0 << winner;
          start_n  = 1'b1;
        end
      end
      ISSUE: begin
        wait_cnt_n = '0;
        state_n    = WAIT;
      end
      WAIT: begin
        // A done arriving on the final timeout cycle still counts as success.
        if (bus.cordic_done) begin
          rsp_x_n     = bus.cordic_x;
          rsp_y_n     = bus.cordic_y;
          rsp_err_n   = 1'b0;
          rsp_valid_n = ONE_HOT0 << owner;
          state_n     = RESP;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          rsp_x_n     = '0;
          rsp_y_n     = '0;
          rsp_err_n   = 1'b1;
          rsp_valid_n = ONE_HOT0 << owner;
          state_n     = RESP;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tick && (|bus.req) && (state != IDLE) && (ovr_q != 8'hFF)) ovr_n = ovr_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      owner       <= '0;
      wait_cnt    <= '0;
      grant_q     <= '0;
      start_q     <= 1'b0;
      angle_q     <= '0;
      rsp_valid_q <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      owner       <= owner_n;
      wait_cnt    <= wait_cnt_n;
      grant_q     <= grant_n;
      start_q     <= start_n;
      angle_q     <= angle_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_x_q     <= rsp_x_n;
      rsp_y_q     <= rsp_y_n;
      rsp_err_q   <= rsp_err_n;
      ovr_q       <= ovr_n;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.cordic_start = start_q;
  assign bus.cordic_angle = angle_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_x        = rsp_x_q;
  assign bus.rsp_y        = rsp_y_q;
  assign bus.rsp_err      = rsp_err_q;
  assign busy             = (state != IDLE);
  assign overrun_cnt      = ovr_q;

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Directed plus randomized bench for cordic_job_scheduler; the bench plays the CORDIC core
// and predicts grant order, response timing/data and the overrun count.
module tb_cordic_job_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       busy;
  logic [7:0] overrun_cnt;

  cordic_job_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  cordic_job_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .bus(bus),
    .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int last_grant = NUM_REQ - 1;
  int ov_model = 0;

  // Round-robin rule: first requester set, scanning upward from the previous winner.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add_overruns(input int n);
    ov_model = (ov_model + n > 255) ? 255 : ov_model + n;
  endtask

  // Issues one job from mask; the core answers d cycles into WAIT (d >= TIMEOUT: never).
  task automatic run_job(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*DATA_W-1:0] angles,
                         input int d, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                         input bit tick_all);
    int w;
    int resp_at;
    bit answered;
    logic [DATA_W-1:0] exp_angle;
    w         = rr_pick(mask, last_grant);
    answered  = (d >= 0) && (d < TIMEOUT);
    resp_at   = answered ? d + 1 : TIMEOUT;
    exp_angle = angles[w*DATA_W +: DATA_W];
    bus.req       = mask;
    bus.req_angle = angles;
    tick          = 1'b1;
    @(negedge clk);
    tick = tick_all;
    if (tick_all) add_overruns(1);
    check_val("grant", 32'(bus.grant), 32'(1 << w));
    check_val("cordic_start", 32'(bus.cordic_start), 32'd1);
    check_val("cordic_angle", 32'(bus.cordic_angle), 32'(exp_angle));
    check_val("busy_issue", 32'(busy), 32'd1);
    last_grant = w;
    @(negedge clk);
    check_val("grant_clear", 32'(bus.grant), 32'd0);
    check_val("start_clear", 32'(bus.cordic_start), 32'd0);
    for (int i = 0; i < resp_at; i++) begin
      check_val("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
      bus.cordic_done = answered && (i == d);
      bus.cordic_x    = x;
      bus.cordic_y    = y;
      if (tick_all) add_overruns(1);
      @(negedge clk);
    end
    bus.cordic_done = 1'b0;
    if (tick_all) add_overruns(1);
    check_val("rsp_valid", 32'(bus.rsp_valid), 32'(1 << w));
    check_val("rsp_x", 32'(bus.rsp_x), answered ? 32'(x) : 32'd0);
    check_val("rsp_y", 32'(bus.rsp_y), answered ? 32'(y) : 32'd0);
    check_val("rsp_err", 32'(bus.rsp_err), answered ? 32'd0 : 32'd1);
    @(negedge clk);
    tick = 1'b0;
    check_val("rsp_valid_clear", 32'(bus.rsp_valid), 32'd0);
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("overrun_cnt", 32'(overrun_cnt), 32'(ov_model));
  endtask

  initial begin
    logic [NUM_REQ-1:0] mask;
    reset           = 1'b1;
    tick            = 1'b0;
    bus.req         = '0;
    bus.req_angle   = '0;
    bus.cordic_done = 1'b0;
    bus.cordic_x    = '0;
    bus.cordic_y    = '0;
    repeat (2) @(negedge clk);
    check_val("reset_grant", 32'(bus.grant), 32'd0);
    check_val("reset_start", 32'(bus.cordic_start), 32'd0);
    check_val("reset_angle", 32'(bus.cordic_angle), 32'd0);
    check_val("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("reset_rsp_xy", {bus.rsp_x, bus.rsp_y}, 32'd0);
    check_val("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_overrun", 32'(overrun_cnt), 32'd0);
    reset = 1'b0;

    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_val("tick_no_req_busy", 32'(busy), 32'd0);
    check_val("tick_no_req_grant", 32'(bus.grant), 32'd0);

    run_job(4'b0001, 64'h0000_0000_0000_2000, 2, 16'h1111, 16'h2222, 1'b0);

    for (int j = 0; j < 5; j++)
      run_job(4'b1111, {$urandom(), $urandom()}, int'($urandom_range(0, 5)),
              16'($urandom()), 16'($urandom()), 1'b0);

    run_job(4'b0100, {$urandom(), $urandom()}, TIMEOUT + 10, 16'hAAAA, 16'hBBBB, 1'b0);
    run_job(4'b0100, {$urandom(), $urandom()}, TIMEOUT - 1, 16'h1234, 16'h5678, 1'b0);

    for (int j = 0; j < 12; j++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      run_job(mask, {$urandom(), $urandom()}, int'($urandom_range(0, TIMEOUT + 2)),
              16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
    end

    run_job(4'b1111, {$urandom(), $urandom()}, 9, 16'h0F0F, 16'hF0F0, 1'b1);
    for (int j = 0; j < 9; j++)
      run_job(4'b1111, {$urandom(), $urandom()}, TIMEOUT, 16'h0, 16'h0, 1'b1);
    check_val("overrun_saturated", 32'(overrun_cnt), 32'd255);

    bus.req       = 4'b0010;
    bus.req_angle = {$urandom(), $urandom()};
    tick          = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_grant = NUM_REQ - 1;
    ov_model   = 0;
    check_val("midjob_reset_busy", 32'(busy), 32'd0);
    check_val("midjob_reset_overrun", 32'(overrun_cnt), 32'd0);
    check_val("midjob_reset_angle", 32'(bus.cordic_angle), 32'd0);
    bus.cordic_done = 1'b1;
    @(negedge clk);
    bus.cordic_done = 1'b0;
    check_val("late_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("late_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_val("late_done_rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    run_job(4'b1111, {$urandom(), $urandom()}, 1, 16'h7777, 16'h8888, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
